// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store memory interface.
//   SZ_B / SZ_H / SZ_W : request size encodings (2'b11 behaves as word)
//   state_t            : sequencer states IDLE, ACCESS, WRITE, DONE
//   is_word()          : size decodes to a full-word access
//   misaligned()       : halfword on odd byte, or word not on a 4-byte boundary
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

    // 2'b10 and 2'b11 are both full-word accesses
    function automatic logic is_word(input logic [1:0] sz);
        return sz[1];
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return ((sz == SZ_H) && lo[0]) || (is_word(sz) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the LSU.
//   mem_rd_i      : full word read from memory
//   wdata_i       : right-aligned store data
//   size_i        : access size (SZ_B / SZ_H / word)
//   unsigned_i    : zero-extend instead of sign-extend on loads
//   addr_lo_i     : byte offset within the word
//   load_data_o   : selected lane, extended to 32 bits
//   merge_data_o  : mem_rd_i with the addressed lane replaced by store data
// Halfword uses only addr_lo_i[1]; word ignores addr_lo_i, so low address
// bits are forced implicitly when misaligned accesses are not trapped.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rd_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = mem_rd_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_h = addr_lo_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    always_comb begin
        load_data_o = mem_rd_i;
        case (size_i)
            SZ_B:    load_data_o = unsigned_i ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_H:    load_data_o = unsigned_i ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data_o = mem_rd_i;
        endcase
    end

    always_comb begin
        merge_data_o = mem_rd_i;
        case (size_i)
            SZ_B:    merge_data_o[{addr_lo_i, 3'b000} +: 8]   = wdata_i[7:0];
            SZ_H:    merge_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit between the memory pipeline stage and a
// word-addressed, word-write-only data memory.
//   clk, reset        : clock, synchronous active-high reset
//   req_*             : valid/ready request (we, size, unsigned, addr, wdata)
//   resp_valid/rdata/err : one-cycle completion pulse with formatted data
//   mem_a/mem_wd/mem_we : word index, write data, write enable to memory
//   mem_rd            : combinational read data for mem_a
// Sub-word stores are read-modify-write: ACCESS reads and merges, WRITE
// commits. Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// requests skip memory and respond next cycle with resp_err = 1.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 6
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    state_t              state_q;
    logic                we_q, uns_q, req_ready_q, resp_valid_q;
    logic [1:0]          size_q;
    logic [MEM_AW+1:0]   addr_q;
    logic [31:0]         wdata_q, merge_q, rdata_q;
    logic [31:0]         load_data, merge_data;

    // byte-address bits above the memory size alias and are dropped
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    lsu_align u_align (
        .mem_rd_i     (mem_rd),
        .wdata_i      (wdata_q),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .addr_lo_i    (addr_q[1:0]),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q        <= req_we;
                    size_q      <= req_size;
                    uns_q       <= req_unsigned;
                    addr_q      <= req_addr[MEM_AW+1:0];
                    wdata_q     <= req_wdata;
                    rdata_q     <= '0;
                    req_ready_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                    end else begin
                        state_q <= ACCESS;
                    end
`else
                    state_q <= ACCESS;
`endif
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q      <= load_data;
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                    end else if (is_word(size_q)) begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                    end else begin
                        merge_q <= merge_data;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    state_q      <= DONE;
                    resp_valid_q <= 1'b1;
                end
                DONE: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (state_q == IDLE && req_valid)
            err_q <= misaligned(req_size, req_addr[1:0]);
    end
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;

    // Memory side comes only from latched state; the write strobe is gated
    // by reset so a reset landing on the commit cycle cancels the write.
    assign mem_a  = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
    assign mem_wd = (state_q == WRITE) ? merge_q : wdata_q;
    assign mem_we = !reset && (((state_q == ACCESS) && we_q && is_word(size_q))
                               || (state_q == WRITE));

endmodule

// File: tb/tb_lsu_mem_if.sv
module tb_lsu_mem_if;
    import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, reset, req_valid, req_ready, req_we, req_unsigned;
    logic        resp_valid, resp_err, mem_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_a, mem_wd, mem_rd;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        bk_we;
    logic [5:0]  bk_idx;
    logic [31:0] bk_val;

    int total = 0;
    int bad   = 0;

    lsu_mem_if #(.MEM_AW(6)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data memory: combinational read, write on rising edge; bench backdoor
    assign mem_rd = mem[mem_a[5:0]];
    always @(posedge clk) begin
        if (bk_we) mem[bk_idx] <= bk_val;
        else if (mem_we) mem[mem_a[5:0]] <= mem_wd;
    end

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nwr;
        logic [31:0] exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        @(negedge clk);
        bk_we = 1'b1; bk_idx = idx[5:0]; bk_val = v;
        @(posedge clk);
        #1 bk_we = 1'b0;
    endtask

    // issue one request from IDLE and observe it to completion
    task automatic run_op(input logic we, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int nwr, output logic [31:0] wa, output logic [31:0] wdat,
                          output logic busy_rdy, output logic rdy_after, output logic extra_resp);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nwr = 0; rd = '0; er = 1'b0; wa = '0; wdat = '0; busy_rdy = 1'b0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_we) begin nwr++; wa = mem_a; wdat = mem_wd; end
            busy_rdy = busy_rdy | req_ready;
            if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_err; end
        end
        @(negedge clk);
        if (mem_we) nwr++;
        rdy_after  = req_ready;
        extra_resp = resp_valid;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic un, input logic [1:0] lo);
        int nb, off;
        longint v;
        if (sz == 2'd0) begin nb = 1; off = lo; end
        else if (sz == 2'd1) begin nb = 2; off = (lo / 2) * 2; end
        else return w;
        v = (longint'(w) >> (off * 8)) % (longint'(1) << (nb * 8));
        if (!un && v >= (longint'(1) << (nb * 8 - 1))) v = v - (longint'(1) << (nb * 8));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] d, input logic [1:0] lo);
        int nb, off;
        logic [31:0] mask;
        if (sz == 2'd0) begin nb = 1; off = lo; end
        else if (sz == 2'd1) begin nb = 2; off = (lo / 2) * 2; end
        else return d;
        mask = 32'(((longint'(1) << (nb * 8)) - 1) << (off * 8));
        return (w & ~mask) | ((d << (off * 8)) & mask);
    endfunction

    initial begin
        int lat, nwr;
        logic [31:0] rd, wa, wdat;
        logic er, busy_rdy, rdy_after, extra;
        string nm;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        bk_we = 1'b0; bk_idx = '0; bk_val = '0;
        for (int i = 0; i < 64; i++) poke(i, 32'h0);
        poke(8, 32'h8081F2F3);
        poke(16, 32'h11223344);
        @(negedge clk);
        chk("rst mem_we", {31'b0, mem_we}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst mem_a", mem_a, 32'h0);
        chk("rst mem_wd", mem_wd, 32'h0);

        // directed table: {we, size, uns, addr, wdata, rdata, err, lat, nwr, wa, wd}
        tv[0] = '{1'b0, SZ_B, 1'b0, 32'h21,  32'h0,  32'hFFFFFFF2, 1'b0, 2, 0, 32'h0,  32'h0};
        tv[1] = '{1'b0, SZ_B, 1'b1, 32'h23,  32'h0,  32'h00000080, 1'b0, 2, 0, 32'h0,  32'h0};
        tv[2] = '{1'b0, SZ_H, 1'b0, 32'h22,  32'h0,  32'hFFFF8081, 1'b0, 2, 0, 32'h0,  32'h0};
        tv[3] = '{1'b0, SZ_H, 1'b1, 32'h22,  32'h0,  32'h00008081, 1'b0, 2, 0, 32'h0,  32'h0};
        tv[4] = '{1'b0, SZ_W, 1'b0, 32'h20,  32'h0,  32'h8081F2F3, 1'b0, 2, 0, 32'h0,  32'h0};
        tv[5] = '{1'b0, SZ_B, 1'b0, 32'h121, 32'h0,  32'hFFFFFFF2, 1'b0, 2, 0, 32'h0,  32'h0};
        tv[6] = '{1'b1, SZ_B, 1'b0, 32'h42,  32'hAA, 32'h0,        1'b0, 3, 1, 32'h10, 32'h11AA3344};
        if (TRAP) begin
            tv[7] = '{1'b0, SZ_W, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0};
            tv[8] = '{1'b0, SZ_H, 1'b0, 32'h23, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0};
        end else begin
            tv[7] = '{1'b0, SZ_W, 1'b0, 32'h42, 32'h0, 32'h11AA3344, 1'b0, 2, 0, 32'h0, 32'h0};
            tv[8] = '{1'b0, SZ_H, 1'b0, 32'h23, 32'h0, 32'hFFFF8081, 1'b0, 2, 0, 32'h0, 32'h0};
        end

        for (int i = 0; i < 9; i++) begin
            run_op(tv[i].we, tv[i].sz, tv[i].un, tv[i].addr, tv[i].wdata,
                   lat, rd, er, nwr, wa, wdat, busy_rdy, rdy_after, extra);
            nm = $sformatf("vec%0d", i);
            chk({nm, " latency"}, 32'(lat), 32'(tv[i].exp_lat));
            chk({nm, " rdata"}, rd, tv[i].exp_rd);
            chk({nm, " err"}, {31'b0, er}, {31'b0, tv[i].exp_err});
            chk({nm, " writes"}, 32'(nwr), 32'(tv[i].exp_nwr));
            chk({nm, " ready busy"}, {31'b0, busy_rdy}, 32'd0);
            chk({nm, " ready after"}, {31'b0, rdy_after}, 32'd1);
            chk({nm, " single pulse"}, {31'b0, extra}, 32'd0);
            if (tv[i].exp_nwr != 0) begin
                chk({nm, " mem_a"}, wa, tv[i].exp_wa);
                chk({nm, " mem_wd"}, wdat, tv[i].exp_wd);
            end
        end

        // word store with a second request held through the busy window
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
        req_addr = 32'h44; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_we = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        chk("sw mem_we T+1", {31'b0, mem_we}, 32'd1);
        chk("sw mem_a T+1", mem_a, 32'h11);
        chk("sw mem_wd T+1", mem_wd, 32'hDEADBEEF);
        chk("sw ready T+1", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("sw resp T+2", {31'b0, resp_valid}, 32'd1);
        chk("sw rdata T+2", resp_rdata, 32'h0);
        chk("sw no we T+2", {31'b0, mem_we}, 32'd0);
        chk("sw ready T+2", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("sw ready T+3", {31'b0, req_ready}, 32'd1);
        chk("sw resp T+3", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("held lw resp T+4", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("held lw resp T+5", {31'b0, resp_valid}, 32'd1);
        chk("held lw rdata", resp_rdata, 32'hDEADBEEF);

        // halfword store cancelled by reset during its commit cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_H; req_addr = 32'h46; req_wdata = 32'h5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("sh access no we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("sh reset gates we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("sh ready after reset", {31'b0, req_ready}, 32'd1);
        chk("sh no resp", {31'b0, resp_valid}, 32'd0);
        chk("sh word unchanged", mem[17], 32'hDEADBEEF);
        @(negedge clk);
        chk("sh no late resp", {31'b0, resp_valid}, 32'd0);

        // random traffic against the reference model
        for (int i = 0; i < 64; i++) begin
            logic [31:0] v;
            v = $urandom;
            ref_mem[i] = v;
            poke(i, v);
        end
        for (int i = 0; i < 150; i++) begin
            logic        we, un, mis;
            logic [1:0]  sz;
            logic [31:0] a, d, e_rd;
            int          idx, e_lat, e_nwr;
            we = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            d  = $urandom;
            idx = (a / 4) % 64;
            mis = TRAP && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && (a % 4) != 0));
            e_rd = 32'h0; e_nwr = 0; e_lat = 2;
            if (mis) begin
                e_lat = 1;
            end else if (!we) begin
                e_rd = ref_load(ref_mem[idx], sz, un, a[1:0]);
            end else begin
                e_nwr = 1;
                if (sz < 2'd2) e_lat = 3;
            end
            run_op(we, sz, un, a, d, lat, rd, er, nwr, wa, wdat, busy_rdy, rdy_after, extra);
            nm = $sformatf("rnd%0d", i);
            chk({nm, " latency"}, 32'(lat), 32'(e_lat));
            chk({nm, " rdata"}, rd, e_rd);
            chk({nm, " err"}, {31'b0, er}, {31'b0, mis});
            chk({nm, " writes"}, 32'(nwr), 32'(e_nwr));
            chk({nm, " ready after"}, {31'b0, rdy_after}, 32'd1);
            if (e_nwr != 0) begin
                ref_mem[idx] = ref_store(ref_mem[idx], sz, d, a[1:0]);
                chk({nm, " mem_a"}, wa, 32'(idx));
                chk({nm, " mem_wd"}, wdat, ref_mem[idx]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
